// File: rtl/pipeif_fetch_if.sv
// ---------------------------------------------------------------------------
// pipeif_fetch_if
// Instruction-memory fetch channel: single-outstanding req/gnt/rvalid
// handshake between the fetch stage (master) and instruction memory (slave).
//   imem_req    : fetch request valid            (master -> slave)
//   imem_addr   : word-aligned fetch address     (master -> slave)
//   imem_gnt    : request accepted this cycle    (slave -> master)
//   imem_rvalid : read data valid                (slave -> master)
//   imem_rdata  : instruction word               (slave -> master)
// ---------------------------------------------------------------------------
interface pipeif_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/pipeif_fetch.sv
// ---------------------------------------------------------------------------
// pipeif_fetch
// Instruction-fetch stage feeding the IF/ID pipeline register. Owns the PC,
// selects the next PC (sequential / branch / jump-register / jump), issues
// one outstanding request at a time to instruction memory and presents
// pc4/ins to IF/ID. A redirect raises jflush so IF/ID squashes the
// wrong-path instruction; a response still in flight at the moment of a
// redirect is dropped when it returns.
//
// Ports:
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   wpcir                 : 1 = IF/ID loads this cycle, 0 = stall
//   pcsource              : 00 seq, 01 branch (bpc), 10 jr (rpc), 11 jump (jpc)
//   bpc, rpc, jpc         : redirect targets (low two bits ignored)
//   imem                  : instruction-memory channel (master modport)
//   pc4                   : pc + 4 to IF/ID
//   ins, ins_valid        : instruction to IF/ID (32'h0 when not valid)
//   jflush                : redirect taken this cycle
//   bubble_cnt            : only with IF_BUBBLE_CNT_EN defined; counts
//                           cycles where IF/ID loads a bubble
//
// Optional feature macro: IF_BUBBLE_CNT_EN
// ---------------------------------------------------------------------------
module pipeif_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           wpcir,
    input  logic [1:0]     pcsource,
    input  logic [31:0]    bpc,
    input  logic [31:0]    rpc,
    input  logic [31:0]    jpc,
    pipeif_fetch_if.master imem,
    output logic [31:0]    pc4,
    output logic [31:0]    ins,
    output logic           ins_valid,
    output logic           jflush
`ifdef IF_BUBBLE_CNT_EN
    ,
    output logic [31:0]    bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'b00,
        ST_WAIT = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        drop_q, drop_d;
    logic [31:0] buf_q, buf_d;

    logic        redirect_s;
    logic [31:0] target_s;
    logic [31:0] target_aligned_s;
    logic        outstanding_s;
    logic        deliver_s;

    assign redirect_s       = wpcir && (pcsource != 2'b00);
    assign jflush           = redirect_s;
    assign target_aligned_s = {target_s[31:2], 2'b00};

    // A request is still in flight after this cycle if it is granted now,
    // or if we are already waiting and the data has not come back yet.
    assign outstanding_s = ((state_q == ST_REQ) && imem.imem_gnt) ||
                           ((state_q == ST_WAIT) && !imem.imem_rvalid);

    // Response for the current pc arriving now (not a stale, dropped one).
    assign deliver_s = (state_q == ST_WAIT) && imem.imem_rvalid && !drop_q;

    assign imem.imem_req  = (state_q == ST_REQ) && !reset;
    assign imem.imem_addr = pc_q;
    assign pc4            = pc_q + 32'd4;

    // Redirect target selection.
    always_comb begin
        target_s = 32'h0000_0000;
        case (pcsource)
            2'b01:   target_s = bpc;
            2'b10:   target_s = rpc;
            2'b11:   target_s = jpc;
            default: target_s = 32'h0000_0000;
        endcase
    end

    // Instruction presented to IF/ID: held buffer, same-cycle bypass, or nop.
    always_comb begin
        ins_valid = 1'b0;
        ins       = 32'h0000_0000;
        if (state_q == ST_HOLD) begin
            ins_valid = 1'b1;
            ins       = buf_q;
        end else if (deliver_s) begin
            ins_valid = 1'b1;
            ins       = imem.imem_rdata;
        end else begin
            ins_valid = 1'b0;
            ins       = 32'h0000_0000;
        end
    end

    // Next-state logic; a redirect overrides every state transition.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        buf_d   = buf_q;
        if (redirect_s) begin
            pc_d  = target_aligned_s;
            buf_d = 32'h0000_0000;
            if (outstanding_s) begin
                // The in-flight response belongs to the old path.
                state_d = ST_WAIT;
                drop_d  = 1'b1;
            end else begin
                state_d = ST_REQ;
                drop_d  = 1'b0;
            end
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (imem.imem_gnt) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (imem.imem_rvalid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = ST_REQ;
                        end else if (wpcir) begin
                            pc_d    = pc_q + 32'd4;
                            state_d = ST_REQ;
                        end else begin
                            buf_d   = imem.imem_rdata;
                            state_d = ST_HOLD;
                        end
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_HOLD: begin
                    if (wpcir) begin
                        pc_d    = pc_q + 32'd4;
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                default: begin
                    state_d = ST_REQ;
                    drop_d  = 1'b0;
                end
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_REQ;
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
            buf_q   <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            buf_q   <= buf_d;
        end
    end

`ifdef IF_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    // A bubble is IF/ID loading while no real instruction is available.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (wpcir && !ins_valid) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end else begin
            bubble_cnt_d = bubble_cnt_q;
        end
    end

    // Bubble counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            bubble_cnt_q <= 32'h0000_0000;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipeif_fetch.sv
module tb_pipeif_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clock;
    logic        reset;
    logic        wpcir;
    logic [1:0]  pcsource;
    logic [31:0] bpc, rpc, jpc;
    logic [31:0] pc4, ins;
    logic        ins_valid, jflush;
`ifdef IF_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt;
`endif

    int errors = 0;
    int checks = 0;

    pipeif_fetch_if imem_bus ();

    pipeif_fetch #(.RESET_PC(RESET_PC)) dut (
        .clock     (clock),
        .reset     (reset),
        .wpcir     (wpcir),
        .pcsource  (pcsource),
        .bpc       (bpc),
        .rpc       (rpc),
        .jpc       (jpc),
        .imem      (imem_bus),
        .pc4       (pc4),
        .ins       (ins),
        .ins_valid (ins_valid),
        .jflush    (jflush)
`ifdef IF_BUBBLE_CNT_EN
        ,
        .bubble_cnt(bubble_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory contents: a bijective scramble of the address.
    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[26:0], a[31:27]} ^ 32'h9E37_79B9;
    endfunction

    task automatic set_in(input logic w, input logic [1:0] ps, input logic g,
                          input logic rv, input logic [31:0] rd);
        wpcir                = w;
        pcsource             = ps;
        imem_bus.imem_gnt    = g;
        imem_bus.imem_rvalid = rv;
        imem_bus.imem_rdata  = rd;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_in(1'b0, 2'b00, 1'b0, 1'b0, 32'h0);
        @(negedge clock);
        checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req_in_reset: got %b want 0", imem_bus.imem_req); end
        next_cycle();
        reset = 1'b0;
        set_in(1'b0, 2'b00, 1'b0, 1'b0, 32'h0);
        @(negedge clock);
        checks++; if (imem_bus.imem_req !== 1'b1) begin errors++; $display("FAIL rst_req: got %b want 1", imem_bus.imem_req); end
        checks++; if (imem_bus.imem_addr !== RESET_PC) begin errors++; $display("FAIL rst_addr: got %h want %h", imem_bus.imem_addr, RESET_PC); end
        checks++; if (pc4 !== RESET_PC + 32'd4) begin errors++; $display("FAIL rst_pc4: got %h want %h", pc4, RESET_PC + 32'd4); end
        checks++; if (ins_valid !== 1'b0 || ins !== 32'h0) begin errors++; $display("FAIL rst_ins: got %b/%h want 0/0", ins_valid, ins); end
        checks++; if (jflush !== 1'b0) begin errors++; $display("FAIL rst_jflush: got %b want 0", jflush); end
        next_cycle();
    endtask

    task automatic test_basic();
        set_in(1'b1, 2'b00, 1'b1, 1'b0, 32'h0);
        @(negedge clock);
        checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0) begin errors++; $display("FAIL basic_req: got %b/%h want 1/0", imem_bus.imem_req, imem_bus.imem_addr); end
        next_cycle();
        set_in(1'b1, 2'b00, 1'b0, 1'b1, 32'h1111_1111);
        @(negedge clock);
        checks++; if (ins_valid !== 1'b1 || ins !== 32'h1111_1111) begin errors++; $display("FAIL basic_ins: got %b/%h want 1/11111111", ins_valid, ins); end
        checks++; if (pc4 !== 32'h4) begin errors++; $display("FAIL basic_pc4: got %h want 4", pc4); end
        next_cycle();
        set_in(1'b1, 2'b00, 1'b0, 1'b0, 32'h0);
        @(negedge clock);
        checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h4) begin errors++; $display("FAIL basic_next_addr: got %b/%h want 1/4", imem_bus.imem_req, imem_bus.imem_addr); end
        next_cycle();
    endtask

    task automatic test_hold();
        set_in(1'b0, 2'b00, 1'b1, 1'b0, 32'h0);
        @(negedge clock);
        checks++; if (imem_bus.imem_addr !== 32'h4) begin errors++; $display("FAIL hold_addr: got %h want 4", imem_bus.imem_addr); end
        next_cycle();
        set_in(1'b0, 2'b00, 1'b0, 1'b1, 32'h2222_2222);
        @(negedge clock);
        checks++; if (ins_valid !== 1'b1 || ins !== 32'h2222_2222) begin errors++; $display("FAIL hold_first: got %b/%h want 1/22222222", ins_valid, ins); end
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 2'b00, 1'b0, 1'b0, $urandom);
            @(negedge clock);
            checks++; if (ins_valid !== 1'b1 || ins !== 32'h2222_2222) begin errors++; $display("FAIL hold_ins[%0d]: got %b/%h want 1/22222222", i, ins_valid, ins); end
            checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL hold_req[%0d]: got %b want 0", i, imem_bus.imem_req); end
            next_cycle();
        end
        set_in(1'b1, 2'b00, 1'b0, 1'b0, 32'h0);
        @(negedge clock);
        checks++; if (ins_valid !== 1'b1 || ins !== 32'h2222_2222) begin errors++; $display("FAIL hold_release: got %b/%h want 1/22222222", ins_valid, ins); end
        next_cycle();
        set_in(1'b0, 2'b00, 1'b0, 1'b0, 32'h0);
        @(negedge clock);
        checks++; if (imem_bus.imem_addr !== 32'h8 || imem_bus.imem_req !== 1'b1) begin errors++; $display("FAIL hold_advance: got %h/%b want 8/1", imem_bus.imem_addr, imem_bus.imem_req); end
        next_cycle();
    endtask

    task automatic test_redirect_drop();
        bpc = 32'h0000_0100;
        set_in(1'b1, 2'b01, 1'b1, 1'b0, 32'h0);
        @(negedge clock);
        checks++; if (jflush !== 1'b1) begin errors++; $display("FAIL drop_jflush: got %b want 1", jflush); end
        next_cycle();
        set_in(1'b1, 2'b00, 1'b0, 1'b1, 32'hDEAD_BEEF);
        @(negedge clock);
        checks++; if (ins_valid !== 1'b0 || ins !== 32'h0) begin errors++; $display("FAIL drop_stale: got %b/%h want 0/0", ins_valid, ins); end
        checks++; if (jflush !== 1'b0) begin errors++; $display("FAIL drop_jflush_clr: got %b want 0", jflush); end
        checks++; if (imem_bus.imem_addr !== 32'h100 || imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL drop_wait: got %h/%b want 100/0", imem_bus.imem_addr, imem_bus.imem_req); end
        next_cycle();
        set_in(1'b0, 2'b00, 1'b0, 1'b0, 32'h0);
        @(negedge clock);
        checks++; if (imem_bus.imem_addr !== 32'h100 || imem_bus.imem_req !== 1'b1) begin errors++; $display("FAIL drop_newreq: got %h/%b want 100/1", imem_bus.imem_addr, imem_bus.imem_req); end
        next_cycle();
    endtask

    task automatic test_jump_req();
        jpc = 32'h0000_0203;
        set_in(1'b1, 2'b11, 1'b0, 1'b0, 32'h0);
        @(negedge clock);
        checks++; if (jflush !== 1'b1 || imem_bus.imem_addr !== 32'h100) begin errors++; $display("FAIL jump_flush: got %b/%h want 1/100", jflush, imem_bus.imem_addr); end
        next_cycle();
        set_in(1'b1, 2'b00, 1'b0, 1'b0, 32'h0);
        @(negedge clock);
        checks++; if (imem_bus.imem_addr !== 32'h200 || imem_bus.imem_req !== 1'b1) begin errors++; $display("FAIL jump_addr: got %h/%b want 200/1", imem_bus.imem_addr, imem_bus.imem_req); end
        checks++; if (jflush !== 1'b0) begin errors++; $display("FAIL jump_flush_once: got %b want 0", jflush); end
        next_cycle();
    endtask

    task automatic test_gnt_stall();
        // Bubbles since reset so far: basic 2, redirect_drop 2, jump_req 2.
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 2'b00, 1'b0, 1'b0, 32'h0);
            @(negedge clock);
            checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h200) begin errors++; $display("FAIL stall_hold[%0d]: got %b/%h want 1/200", i, imem_bus.imem_req, imem_bus.imem_addr); end
`ifdef IF_BUBBLE_CNT_EN
            checks++; if (bubble_cnt !== 32'd6 + 32'(i)) begin errors++; $display("FAIL stall_bubble[%0d]: got %0d want %0d", i, bubble_cnt, 6 + i); end
`endif
            next_cycle();
        end
    endtask

    task automatic test_reset_in_wait();
        set_in(1'b0, 2'b00, 1'b1, 1'b0, 32'h0);
        @(negedge clock);
        checks++; if (imem_bus.imem_addr !== 32'h200) begin errors++; $display("FAIL rw_addr: got %h want 200", imem_bus.imem_addr); end
        next_cycle();
        reset = 1'b1;
        set_in(1'b0, 2'b00, 1'b0, 1'b0, 32'h0);
        @(negedge clock);
        checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL rw_req_reset: got %b want 0", imem_bus.imem_req); end
        next_cycle();
        reset = 1'b0;
        set_in(1'b0, 2'b00, 1'b0, 1'b1, 32'h3333_3333);
        @(negedge clock);
        checks++; if (ins_valid !== 1'b0 || ins !== 32'h0) begin errors++; $display("FAIL rw_stray: got %b/%h want 0/0", ins_valid, ins); end
        checks++; if (imem_bus.imem_addr !== RESET_PC || imem_bus.imem_req !== 1'b1) begin errors++; $display("FAIL rw_state: got %h/%b want %h/1", imem_bus.imem_addr, imem_bus.imem_req, RESET_PC); end
        next_cycle();
        set_in(1'b0, 2'b00, 1'b0, 1'b0, 32'h0);
        @(negedge clock);
        checks++; if (imem_bus.imem_req !== 1'b1 || ins_valid !== 1'b0) begin errors++; $display("FAIL rw_after: got %b/%b want 1/0", imem_bus.imem_req, ins_valid); end
        next_cycle();
    endtask

    task automatic test_wrap();
        jpc = 32'hFFFF_FFFE;
        set_in(1'b1, 2'b11, 1'b0, 1'b0, 32'h0);
        @(negedge clock);
        checks++; if (jflush !== 1'b1) begin errors++; $display("FAIL wrap_flush: got %b want 1", jflush); end
        next_cycle();
        set_in(1'b0, 2'b00, 1'b1, 1'b0, 32'h0);
        @(negedge clock);
        checks++; if (imem_bus.imem_addr !== 32'hFFFF_FFFC || pc4 !== 32'h0) begin errors++; $display("FAIL wrap_top: got %h/%h want fffffffc/0", imem_bus.imem_addr, pc4); end
        next_cycle();
        set_in(1'b1, 2'b00, 1'b0, 1'b1, 32'hCAFE_F00D);
        @(negedge clock);
        checks++; if (ins_valid !== 1'b1 || ins !== 32'hCAFE_F00D) begin errors++; $display("FAIL wrap_ins: got %b/%h want 1/cafef00d", ins_valid, ins); end
        next_cycle();
        set_in(1'b0, 2'b00, 1'b0, 1'b0, 32'h0);
        @(negedge clock);
        checks++; if (imem_bus.imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_zero: got %h want 0", imem_bus.imem_addr); end
        next_cycle();
    endtask

    // Random traffic against an epoch-based model: every pc change opens a
    // new epoch; a response is valid only if its request was granted in the
    // current epoch, and an unconsumed valid word is held until pc moves.
    task automatic test_random();
        logic [31:0] m_pc, m_addr, tgt, rd;
        logic        m_out, m_held, e_valid, e_req, redir, w, g, rv;
        logic [1:0]  ps;
        int          m_ep, m_ep_req, m_lat, delivered;
        logic [31:0] m_bub;

        reset = 1'b1;
        set_in(1'b0, 2'b00, 1'b0, 1'b0, 32'h0);
        next_cycle();
        reset = 1'b0;
        m_pc = RESET_PC; m_addr = 32'h0; m_out = 1'b0; m_held = 1'b0;
        m_ep = 0; m_ep_req = 0; m_lat = 0; delivered = 0; m_bub = 32'h0;

        for (int c = 0; c < 3000; c++) begin
            w  = ($urandom_range(0, 9) < 7);
            ps = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            bpc = $urandom;
            rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : $urandom;
            jpc = $urandom;
            g   = ($urandom_range(0, 9) < 6);
            rv  = m_out && (m_lat == 0);
            rd  = rv ? memfn(m_addr) : $urandom;
            set_in(w, ps, g, rv, rd);

            redir   = w && (ps != 2'b00);
            e_valid = m_held || (rv && (m_ep_req == m_ep));
            e_req   = !m_out && !m_held;
            case (ps)
                2'b01:   tgt = bpc;
                2'b10:   tgt = rpc;
                2'b11:   tgt = jpc;
                default: tgt = 32'h0;
            endcase

            @(negedge clock);
            checks++; if (imem_bus.imem_addr !== m_pc) begin errors++; $display("FAIL rnd_addr@%0d: got %h want %h", c, imem_bus.imem_addr, m_pc); end
            checks++; if (pc4 !== m_pc + 32'd4) begin errors++; $display("FAIL rnd_pc4@%0d: got %h want %h", c, pc4, m_pc + 32'd4); end
            checks++; if (jflush !== redir) begin errors++; $display("FAIL rnd_jflush@%0d: got %b want %b", c, jflush, redir); end
            checks++; if (imem_bus.imem_req !== e_req) begin errors++; $display("FAIL rnd_req@%0d: got %b want %b", c, imem_bus.imem_req, e_req); end
            checks++; if (ins_valid !== e_valid) begin errors++; $display("FAIL rnd_valid@%0d: got %b want %b", c, ins_valid, e_valid); end
            checks++; if (ins !== (e_valid ? memfn(m_pc) : 32'h0)) begin errors++; $display("FAIL rnd_ins@%0d: got %h want %h", c, ins, e_valid ? memfn(m_pc) : 32'h0); end
`ifdef IF_BUBBLE_CNT_EN
            checks++; if (bubble_cnt !== m_bub) begin errors++; $display("FAIL rnd_bubble@%0d: got %0d want %0d", c, bubble_cnt, m_bub); end
`endif
            if (e_valid) delivered++;
            if (w && !e_valid) m_bub = m_bub + 32'd1;

            if (rv) m_out = 1'b0;
            if (e_req && g) begin
                m_out    = 1'b1;
                m_addr   = m_pc;
                m_ep_req = m_ep;
                m_lat    = $urandom_range(0, 2);
            end else if (m_out && m_lat != 0) begin
                m_lat--;
            end

            if (redir) begin
                m_pc   = {tgt[31:2], 2'b00};
                m_ep++;
                m_held = 1'b0;
            end else if (w && e_valid) begin
                m_pc   = m_pc + 32'd4;
                m_ep++;
                m_held = 1'b0;
            end else if (e_valid) begin
                m_held = 1'b1;
            end
            next_cycle();
        end
        checks++; if (delivered < 200) begin errors++; $display("FAIL rnd_progress: got %0d instructions want at least 200", delivered); end
    endtask

    initial begin
        reset = 1'b1;
        bpc = 32'h0; rpc = 32'h0; jpc = 32'h0;
        set_in(1'b0, 2'b00, 1'b0, 1'b0, 32'h0);
        #1;
        test_reset();
        test_basic();
        test_hold();
        test_redirect_drop();
        test_jump_req();
        test_gnt_stall();
        test_reset_in_wait();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
